// File: rtl/sram_ctrl.sv
// Sequences one CPU word/byte access at a time into active-low SRAM strobes with fixed wait states.
// Latency: read Ready at accept+RD_WAIT+2, write at accept+WR_WAIT+4, null (no lanes) at accept+1.
// Backpressure: Busy is high outside IDLE and Req is ignored until the controller returns to IDLE.
module sram_ctrl #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 16,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    input  logic              We,
    input  logic              Ub,
    input  logic              Lb,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] Wdata,
    output logic [DATA_W-1:0] Rdata,
    output logic              Ready,
    output logic              Busy,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    input  logic [DATA_W-1:0] SRAM_DQ_in,
    output logic [DATA_W-1:0] SRAM_DQ_out,
    output logic              SRAM_DQ_oe
);

    localparam int          HB     = DATA_W / 2;
    localparam logic [3:0]  RD_CNT = 4'(RD_WAIT);
    localparam logic [3:0]  WR_CNT = 4'(WR_WAIT);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t              state, state_nxt;
    logic [3:0]          wait_cnt;
    logic                lat_ub, lat_lb;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic                accept;

    assign accept = (state == IDLE) && Req;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (Req) begin
                    if (!Ub && !Lb) state_nxt = DONE;
                    else if (We)    state_nxt = WR_SETUP;
                    else            state_nxt = RD;
                end
            end
            RD:       if (wait_cnt == 4'd0) state_nxt = DONE;
            WR_SETUP: state_nxt = WR_PULSE;
            WR_PULSE: if (wait_cnt == 4'd0) state_nxt = WR_HOLD;
            WR_HOLD:  state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Request fields are held for the whole access so address/data stay stable on the pins.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wait_cnt  <= 4'd0;
            lat_ub    <= 1'b0;
            lat_lb    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            Rdata     <= '0;
        end else begin
            if (accept) begin
                lat_ub    <= Ub;
                lat_lb    <= Lb;
                lat_addr  <= Addr;
                lat_wdata <= Wdata;
            end
            if (accept && !We && (Ub || Lb))
                wait_cnt <= RD_CNT;
            else if (state == WR_SETUP)
                wait_cnt <= WR_CNT;
            else if ((state == RD || state == WR_PULSE) && wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;
            if (state == RD && wait_cnt == 4'd0)
                Rdata <= {lat_ub ? SRAM_DQ_in[DATA_W-1:HB] : {(DATA_W-HB){1'b0}},
                          lat_lb ? SRAM_DQ_in[HB-1:0]      : {HB{1'b0}}};
        end
    end

    assign SRAM_ADDR   = lat_addr;
    assign SRAM_DQ_out = lat_wdata;

    always_comb begin
        SRAM_CE_N  = 1'b1;
        SRAM_OE_N  = 1'b1;
        SRAM_WE_N  = 1'b1;
        SRAM_UB_N  = 1'b1;
        SRAM_LB_N  = 1'b1;
        SRAM_DQ_oe = 1'b0;
        Ready      = 1'b0;
        Busy       = (state != IDLE);
        case (state)
            RD: begin
                SRAM_CE_N = 1'b0;
                SRAM_OE_N = 1'b0;
                SRAM_UB_N = ~lat_ub;
                SRAM_LB_N = ~lat_lb;
            end
            WR_SETUP, WR_PULSE, WR_HOLD: begin
                SRAM_CE_N  = 1'b0;
                SRAM_WE_N  = (state != WR_PULSE);
                SRAM_UB_N  = ~lat_ub;
                SRAM_LB_N  = ~lat_lb;
                SRAM_DQ_oe = 1'b1;
            end
            DONE:    Ready = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Drives two controllers (wait states 2/2 and 0/0) with shared stimulus against a cycle-offset reference model.
module tb_sram_ctrl;
    localparam int AW = 20;
    localparam int DW = 16;

    logic          Clk = 1'b0;
    logic          Reset, Req, We, Ub, Lb;
    logic [AW-1:0] Addr;
    logic [DW-1:0] Wdata, dq_in;

    logic [DW-1:0] rdata_a, rdata_b, dqout_a, dqout_b;
    logic [AW-1:0] addr_a, addr_b;
    logic          ready_a, busy_a, ce_a, oe_a, we_a, ub_a, lb_a, dqoe_a;
    logic          ready_b, busy_b, ce_b, oe_b, we_b, ub_b, lb_b, dqoe_b;

    always #5 Clk = ~Clk;

    sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(2), .WR_WAIT(2)) dut_a (
        .Clk(Clk), .Reset(Reset), .Req(Req), .We(We), .Ub(Ub), .Lb(Lb), .Addr(Addr), .Wdata(Wdata),
        .Rdata(rdata_a), .Ready(ready_a), .Busy(busy_a), .SRAM_ADDR(addr_a),
        .SRAM_CE_N(ce_a), .SRAM_OE_N(oe_a), .SRAM_WE_N(we_a), .SRAM_UB_N(ub_a), .SRAM_LB_N(lb_a),
        .SRAM_DQ_in(dq_in), .SRAM_DQ_out(dqout_a), .SRAM_DQ_oe(dqoe_a));

    sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(0), .WR_WAIT(0)) dut_b (
        .Clk(Clk), .Reset(Reset), .Req(Req), .We(We), .Ub(Ub), .Lb(Lb), .Addr(Addr), .Wdata(Wdata),
        .Rdata(rdata_b), .Ready(ready_b), .Busy(busy_b), .SRAM_ADDR(addr_b),
        .SRAM_CE_N(ce_b), .SRAM_OE_N(oe_b), .SRAM_WE_N(we_b), .SRAM_UB_N(ub_b), .SRAM_LB_N(lb_b),
        .SRAM_DQ_in(dq_in), .SRAM_DQ_out(dqout_b), .SRAM_DQ_oe(dqoe_b));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: a request is a timeline of cycle offsets k = 1..lat after the accepting edge.
    int            rw [2] = '{2, 0};
    int            ww [2] = '{2, 0};
    bit            m_busy [2];
    int            m_k [2], m_lat [2], m_kind [2];   // kind: 0 read, 1 write, 2 null
    logic          m_ub [2], m_lb [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_wdata [2], m_rdata [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_k[d] = 0; m_lat[d] = 0; m_kind[d] = 2;
            m_ub[d] = 0; m_lb[d] = 0; m_addr[d] = '0; m_wdata[d] = '0; m_rdata[d] = '0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (!m_busy[d]) begin
                if (Req) begin
                    m_busy[d] = 1; m_k[d] = 1;
                    m_ub[d] = Ub; m_lb[d] = Lb; m_addr[d] = Addr; m_wdata[d] = Wdata;
                    m_kind[d] = (!Ub && !Lb) ? 2 : (We ? 1 : 0);
                    m_lat[d]  = (m_kind[d] == 2) ? 1 : (m_kind[d] == 0 ? rw[d] + 2 : ww[d] + 4);
                end
            end else begin
                if (m_kind[d] == 0 && m_k[d] == rw[d] + 1)
                    m_rdata[d] = {m_ub[d] ? dq_in[15:8] : 8'h00, m_lb[d] ? dq_in[7:0] : 8'h00};
                if (m_k[d] == m_lat[d]) m_busy[d] = 0;
                else                    m_k[d]++;
            end
        end
    endtask

    // {ce_n, oe_n, we_n, ub_n, lb_n, dq_oe, ready, busy}
    function automatic logic [7:0] exp_strb(input int d);
        logic ce = 1, oe = 1, we = 1, ub = 1, lb = 1, dqoe = 0, rdy = 0;
        if (m_busy[d]) begin
            if (m_k[d] == m_lat[d]) rdy = 1;
            if (m_kind[d] == 0 && m_k[d] <= rw[d] + 1) begin
                ce = 0; oe = 0; ub = ~m_ub[d]; lb = ~m_lb[d];
            end
            if (m_kind[d] == 1 && m_k[d] <= ww[d] + 3) begin
                ce = 0; ub = ~m_ub[d]; lb = ~m_lb[d]; dqoe = 1;
                we = (m_k[d] >= 2 && m_k[d] <= ww[d] + 2) ? 1'b0 : 1'b1;
            end
        end
        return {ce, oe, we, ub, lb, dqoe, rdy, m_busy[d]};
    endfunction

    task automatic check_all();
        check("strb_w2",  32'({ce_a, oe_a, we_a, ub_a, lb_a, dqoe_a, ready_a, busy_a}), 32'(exp_strb(0)));
        check("strb_w0",  32'({ce_b, oe_b, we_b, ub_b, lb_b, dqoe_b, ready_b, busy_b}), 32'(exp_strb(1)));
        check("addr_w2",  32'(addr_a),  32'(m_addr[0]));
        check("addr_w0",  32'(addr_b),  32'(m_addr[1]));
        check("dqout_w2", 32'(dqout_a), 32'(m_wdata[0]));
        check("dqout_w0", 32'(dqout_b), 32'(m_wdata[1]));
        check("rdata_w2", 32'(rdata_a), 32'(m_rdata[0]));
        check("rdata_w0", 32'(rdata_b), 32'(m_rdata[1]));
        check("oe_we_excl", 32'({oe_a | we_a, oe_b | we_b}), 32'(2'b11));
    endtask

    task automatic step(input logic req, input logic wr, input logic ub, input logic lb,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [DW-1:0] dq);
        Req = req; We = wr; Ub = ub; Lb = lb; Addr = a; Wdata = wd; dq_in = dq;
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        check_all();
    endtask

    task automatic idle(input int n, input logic [DW-1:0] dq);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 20'h0, 16'h0, dq);
    endtask

    initial begin
        Reset = 1'b0; Req = 0; We = 0; Ub = 0; Lb = 0; Addr = '0; Wdata = '0; dq_in = '0;
        model_reset();
        repeat (3) @(negedge Clk);
        check_all();
        Reset = 1'b1;

        // Full-word read, write, upper-byte read, null request
        step(1, 0, 1, 1, 20'h00010, 16'h0000, 16'hBEEF);  idle(6, 16'hBEEF);
        step(1, 1, 1, 1, 20'h00020, 16'h1234, 16'h0000);  idle(7, 16'h0000);
        step(1, 0, 1, 0, 20'h00030, 16'h0000, 16'hABCD);  idle(5, 16'hABCD);
        step(1, 0, 0, 0, 20'h00040, 16'h9999, 16'h5555);  idle(3, 16'h5555);

        // Req held high across back-to-back reads
        for (int i = 0; i < 20; i++) step(1, 0, 1, 1, 20'($urandom), 16'h0, 16'($urandom));
        idle(5, 16'h0);

        // Req pulsed again while a read is in flight
        step(1, 0, 1, 1, 20'h00060, 16'h0, 16'h1357);
        step(0, 0, 1, 1, 20'h0,     16'h0, 16'h1357);
        step(1, 1, 1, 1, 20'h00070, 16'hFFFF, 16'h1357);
        step(0, 0, 1, 1, 20'h0,     16'h0, 16'h1357);
        idle(5, 16'h2468);

        // Asynchronous reset during the write pulse
        step(1, 1, 1, 1, 20'h00020, 16'h1234, 16'h0);
        idle(2, 16'h0);
        Req = 0;
        #2 Reset = 1'b0;
        #1 model_reset();
        check_all();
        @(posedge Clk);
        @(negedge Clk);
        check_all();
        Reset = 1'b1;
        step(1, 0, 1, 1, 20'h00050, 16'h0, 16'h7777);  idle(5, 16'h7777);

        // Random traffic
        for (int i = 0; i < 800; i++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 4) != 0),
                 1'($urandom_range(0, 4) != 0), 20'($urandom), 16'($urandom), 16'($urandom));
        idle(8, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
